pipe_ctrl_unit: RTL and testbench

Parametrised pipeline control unit for the 5-stage RV32 core; replaces the separate hazard-detection and forwarding logic. It keeps a shadow scoreboard of the ID/EX, EX/MEM and MEM/WB stages and drives per-stage enables, bubbles and the branch redirect select. It also drives the forwarding selects and the performance counters. It adds support for multi-cycle EX ops (MC_LAT), multi-cycle data memory (MEM_LAT) and a no-forwarding mode.

---
 rtl/pipe_ctrl_pkg.sv | 42 ++++
 rtl/pipe_fwd_sel.sv | 28 ++
 rtl/pipe_ctrl_unit.sv | 211 +++++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline control unit: forwarding selects, shadow
// stage record, control-condition priorities and the register-match helper.
package pipe_ctrl_pkg;

    // Widest register index the shadow records can hold.
    // RF_ADDRESS on the top must not exceed this; narrower indices are zero-extended.
    localparam int RF_AW_MAX = 8;

    typedef logic [RF_AW_MAX-1:0] rf_addr_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic     valid;
        rf_addr_t rs1;
        rf_addr_t rs2;
        rf_addr_t rd;
        logic     regwrite;
        logic     memread;
        logic     memwrite;
        logic     multicycle;
    } stage_meta_t;

    // Control conditions; only the highest-priority active one drives the pipeline
    typedef enum logic [2:0] {
        COND_NONE,
        COND_LOAD_USE,
        COND_REDIRECT,
        COND_EX_WAIT,
        COND_MEM_WAIT
    } ctrl_cond_t;

    // True when a stage will write a non-zero register equal to rs
    function automatic logic rd_hits(input stage_meta_t s, input rf_addr_t rs);
        return s.valid && s.regwrite && (s.rd != '0) && (s.rd == rs);
    endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// Forwarding select for one EX source operand, from the MEM and WB shadow records.
module pipe_fwd_sel
    import pipe_ctrl_pkg::*;
#(
    parameter int FWD_EN = 1
) (
    input  stage_meta_t mem_meta,
    input  stage_meta_t wb_meta,
    input  rf_addr_t    ex_rs,
    output fwd_sel_t    sel
);

    logic unused_meta;
    assign unused_meta = ^{mem_meta, wb_meta};

    // The MEM result is younger than WB data, so it wins when both match
    always_comb begin
        sel = FWD_REG;
        if (FWD_EN != 0) begin
            if (rd_hits(mem_meta, ex_rs)) begin
                sel = FWD_MEM;
            end else if (rd_hits(wb_meta, ex_rs)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control for the 5-stage RV32 core: shadow scoreboard of ID/EX,
// EX/MEM and MEM/WB, stall/flush/bubble control, forwarding selects and
// performance counters.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int RF_ADDRESS = 5,
    parameter int MC_LAT     = 4,
    parameter int MEM_LAT    = 1,
    parameter int FWD_EN     = 1,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [RF_ADDRESS-1:0] id_rs1,
    input  logic [RF_ADDRESS-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [RF_ADDRESS-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  id_memwrite,
    input  logic                  id_multicycle,
    input  logic                  br_taken,
    output logic                  en_pc,
    output logic                  en_ifid,
    output logic                  en_idex,
    output logic                  en_exmem,
    output logic                  en_memwb,
    output logic                  flush_ifid,
    output logic                  bubble_idex,
    output logic                  bubble_exmem,
    output logic                  bubble_memwb,
    output logic                  pc_sel,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  ex_busy,
    output logic                  mem_busy,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int EXC_W  = $clog2(MC_LAT + 1);
    localparam int MEMC_W = $clog2(MEM_LAT + 1);
    localparam logic [EXC_W-1:0]  EX_LAST  = EXC_W'(MC_LAT - 1);
    localparam logic [MEMC_W-1:0] MEM_LAST = MEMC_W'(MEM_LAT - 1);

    stage_meta_t       id_meta;
    stage_meta_t       ex_q;
    stage_meta_t       mem_q;
    stage_meta_t       wb_q;
    logic [EXC_W-1:0]  ex_cnt;
    logic [MEMC_W-1:0] mem_cnt;
    logic              mem_wait;
    logic              ex_wait;
    logic              redirect;
    logic              lu_fwd;
    logic              lu_nofwd;
    logic              load_use;
    ctrl_cond_t        cond;
    fwd_sel_t          fwd_a;
    fwd_sel_t          fwd_b;
    logic              unused_meta;

    assign unused_meta = ^{mem_q, wb_q};

    // Wait counters never pass their last value, so "!=" is the same test as "<"
    // Build the ID record, evaluate every hazard and pick the acting condition
    always_comb begin
        id_meta            = '0;
        id_meta.valid      = id_valid;
        id_meta.rs1        = rf_addr_t'(id_rs1);
        id_meta.rs2        = rf_addr_t'(id_rs2);
        id_meta.rd         = rf_addr_t'(id_rd);
        id_meta.regwrite   = id_regwrite;
        id_meta.memread    = id_memread;
        id_meta.memwrite   = id_memwrite;
        id_meta.multicycle = id_multicycle;

        mem_wait = mem_q.valid && (mem_q.memread || mem_q.memwrite) && (mem_cnt != MEM_LAST);
        ex_wait  = ex_q.valid && ex_q.multicycle && (ex_cnt != EX_LAST);
        redirect = br_taken && ex_q.valid;

        lu_fwd = ex_q.memread &&
                 ((id_use_rs1 && rd_hits(ex_q, id_meta.rs1)) ||
                  (id_use_rs2 && rd_hits(ex_q, id_meta.rs2)));

        lu_nofwd = (id_use_rs1 && (rd_hits(ex_q, id_meta.rs1) ||
                                   rd_hits(mem_q, id_meta.rs1) ||
                                   rd_hits(wb_q, id_meta.rs1))) ||
                   (id_use_rs2 && (rd_hits(ex_q, id_meta.rs2) ||
                                   rd_hits(mem_q, id_meta.rs2) ||
                                   rd_hits(wb_q, id_meta.rs2)));

        load_use = id_valid && ((FWD_EN != 0) ? lu_fwd : lu_nofwd);

        if (reset)         cond = COND_NONE;
        else if (mem_wait) cond = COND_MEM_WAIT;
        else if (ex_wait)  cond = COND_EX_WAIT;
        else if (redirect) cond = COND_REDIRECT;
        else if (load_use) cond = COND_LOAD_USE;
        else               cond = COND_NONE;
    end

    // Translate the acting condition into stage enables, bubbles and redirect
    always_comb begin
        en_pc        = 1'b1;
        en_ifid      = 1'b1;
        en_idex      = 1'b1;
        en_exmem     = 1'b1;
        en_memwb     = 1'b1;
        flush_ifid   = 1'b0;
        bubble_idex  = 1'b0;
        bubble_exmem = 1'b0;
        bubble_memwb = 1'b0;
        pc_sel       = 1'b0;
        case (cond)
            COND_MEM_WAIT: begin
                en_pc        = 1'b0;
                en_ifid      = 1'b0;
                en_idex      = 1'b0;
                en_exmem     = 1'b0;
                bubble_memwb = 1'b1;
            end
            COND_EX_WAIT: begin
                en_pc        = 1'b0;
                en_ifid      = 1'b0;
                en_idex      = 1'b0;
                bubble_exmem = 1'b1;
            end
            COND_REDIRECT: begin
                pc_sel      = 1'b1;
                flush_ifid  = 1'b1;
                bubble_idex = 1'b1;
            end
            COND_LOAD_USE: begin
                en_pc       = 1'b0;
                en_ifid     = 1'b0;
                bubble_idex = 1'b1;
            end
            default: ;
        endcase
    end

    pipe_fwd_sel #(
        .FWD_EN (FWD_EN)
    ) u_fwd_a (
        .mem_meta (mem_q),
        .wb_meta  (wb_q),
        .ex_rs    (ex_q.rs1),
        .sel      (fwd_a)
    );

    pipe_fwd_sel #(
        .FWD_EN (FWD_EN)
    ) u_fwd_b (
        .mem_meta (mem_q),
        .wb_meta  (wb_q),
        .ex_rs    (ex_q.rs2),
        .sel      (fwd_b)
    );

    assign fwd_a_sel = reset ? FWD_REG : fwd_a;
    assign fwd_b_sel = reset ? FWD_REG : fwd_b;
    assign ex_busy   = ex_wait && !reset;
    assign mem_busy  = mem_wait && !reset;

    // Shadow stages follow the enables and bubbles driven above
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            if (en_idex)  ex_q  <= bubble_idex  ? '0 : id_meta;
            if (en_exmem) mem_q <= bubble_exmem ? '0 : ex_q;
            if (en_memwb) wb_q  <= bubble_memwb ? '0 : mem_q;
        end
    end

    // Occupancy counters restart on stage entry and advance while waiting
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_cnt  <= '0;
            mem_cnt <= '0;
        end else begin
            if (en_idex)       ex_cnt <= '0;
            else if (ex_wait)  ex_cnt <= ex_cnt + EXC_W'(1);
            if (en_exmem)      mem_cnt <= '0;
            else if (mem_wait) mem_cnt <= mem_cnt + MEMC_W'(1);
        end
    end

    // Saturating performance counters for stall and redirect cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if ((cond == COND_MEM_WAIT || cond == COND_EX_WAIT || cond == COND_LOAD_USE) &&
                (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (pc_sel && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: three instances (defaults, MEM_LAT=3,
// FWD_EN=0) share one ID stimulus; each scenario starts from reset.
module tb_pipe_ctrl_unit;

    // {en_pc,en_ifid,en_idex,en_exmem,en_memwb,flush_ifid,bubble_idex,bubble_exmem,bubble_memwb,pc_sel}
    localparam logic [9:0] C_NONE  = 10'b11111_0000_0;
    localparam logic [9:0] C_MEMW  = 10'b00001_0001_0;
    localparam logic [9:0] C_EXW   = 10'b00011_0010_0;
    localparam logic [9:0] C_REDIR = 10'b11111_1100_1;
    localparam logic [9:0] C_LU    = 10'b00111_0100_0;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2;
    logic       id_regwrite, id_memread, id_memwrite, id_multicycle;
    logic       br_taken;

    logic        en_pc[3], en_ifid[3], en_idex[3], en_exmem[3], en_memwb[3];
    logic        flush_ifid[3], bubble_idex[3], bubble_exmem[3], bubble_memwb[3], pc_sel[3];
    logic        ex_busy[3], mem_busy[3];
    logic [1:0]  fwd_a_sel[3], fwd_b_sel[3];
    logic [31:0] stall_cycles[3], flush_count[3];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit u_def (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_multicycle(id_multicycle), .br_taken(br_taken),
        .en_pc(en_pc[0]), .en_ifid(en_ifid[0]), .en_idex(en_idex[0]), .en_exmem(en_exmem[0]),
        .en_memwb(en_memwb[0]), .flush_ifid(flush_ifid[0]), .bubble_idex(bubble_idex[0]),
        .bubble_exmem(bubble_exmem[0]), .bubble_memwb(bubble_memwb[0]), .pc_sel(pc_sel[0]),
        .fwd_a_sel(fwd_a_sel[0]), .fwd_b_sel(fwd_b_sel[0]), .ex_busy(ex_busy[0]),
        .mem_busy(mem_busy[0]), .stall_cycles(stall_cycles[0]), .flush_count(flush_count[0])
    );

    pipe_ctrl_unit #(.MEM_LAT(3)) u_mem (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_multicycle(id_multicycle), .br_taken(br_taken),
        .en_pc(en_pc[1]), .en_ifid(en_ifid[1]), .en_idex(en_idex[1]), .en_exmem(en_exmem[1]),
        .en_memwb(en_memwb[1]), .flush_ifid(flush_ifid[1]), .bubble_idex(bubble_idex[1]),
        .bubble_exmem(bubble_exmem[1]), .bubble_memwb(bubble_memwb[1]), .pc_sel(pc_sel[1]),
        .fwd_a_sel(fwd_a_sel[1]), .fwd_b_sel(fwd_b_sel[1]), .ex_busy(ex_busy[1]),
        .mem_busy(mem_busy[1]), .stall_cycles(stall_cycles[1]), .flush_count(flush_count[1])
    );

    pipe_ctrl_unit #(.FWD_EN(0)) u_nofwd (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_multicycle(id_multicycle), .br_taken(br_taken),
        .en_pc(en_pc[2]), .en_ifid(en_ifid[2]), .en_idex(en_idex[2]), .en_exmem(en_exmem[2]),
        .en_memwb(en_memwb[2]), .flush_ifid(flush_ifid[2]), .bubble_idex(bubble_idex[2]),
        .bubble_exmem(bubble_exmem[2]), .bubble_memwb(bubble_memwb[2]), .pc_sel(pc_sel[2]),
        .fwd_a_sel(fwd_a_sel[2]), .fwd_b_sel(fwd_b_sel[2]), .ex_busy(ex_busy[2]),
        .mem_busy(mem_busy[2]), .stall_cycles(stall_cycles[2]), .flush_count(flush_count[2])
    );

    function automatic logic [9:0] ctl(input int k);
        return {en_pc[k], en_ifid[k], en_idex[k], en_exmem[k], en_memwb[k],
                flush_ifid[k], bubble_idex[k], bubble_exmem[k], bubble_memwb[k], pc_sel[k]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic u1, input logic u2, input logic [4:0] rd,
                            input logic rw, input logic mr, input logic mw, input logic mc);
        id_valid      = v;
        id_rs1        = rs1;
        id_rs2        = rs2;
        id_use_rs1    = u1;
        id_use_rs2    = u2;
        id_rd         = rd;
        id_regwrite   = rw;
        id_memread    = mr;
        id_memwrite   = mw;
        id_multicycle = mc;
    endtask

    task automatic nop_id;
        drive_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic do_reset;
        reset    = 1'b1;
        br_taken = 1'b0;
        nop_id();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Outputs while reset is held, with hazardous-looking inputs present
        reset    = 1'b1;
        br_taken = 1'b1;
        drive_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_ctl%0d", k), ctl(k), C_NONE);
            chk($sformatf("rst_fwd%0d", k), {fwd_a_sel[k], fwd_b_sel[k]}, 4'b0000);
            chk($sformatf("rst_busy%0d", k), {ex_busy[k], mem_busy[k]}, 2'b00);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_cnt%0d", k), stall_cycles[k] | flush_count[k], 0);
        end

        // lw x5 ; add x6,x5,x1 -> one load-use stall, then WB forwarding
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        settle();
        chk("lu_c0_ctl", ctl(0), C_NONE);
        tick();
        drive_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        chk("lu_stall_ctl", ctl(0), C_LU);
        tick();
        settle();
        chk("lu_after_ctl", ctl(0), C_NONE);
        chk("lu_stall_cnt", stall_cycles[0], 1);
        tick();
        nop_id();
        settle();
        chk("lu_fwd_a", fwd_a_sel[0], 2'b01);
        chk("lu_fwd_b", fwd_b_sel[0], 2'b00);
        chk("lu_stall_cnt2", stall_cycles[0], 1);

        // add x5 ; sub x7,x5,x5 -> no stall, both operands from EX/MEM
        do_reset();
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        chk("alu_ctl", ctl(0), C_NONE);
        tick();
        nop_id();
        settle();
        chk("alu_fwd_a", fwd_a_sel[0], 2'b10);
        chk("alu_fwd_b", fwd_b_sel[0], 2'b10);
        chk("alu_stall_cnt", stall_cycles[0], 0);

        // Boundaries: rd=x0, id_valid=0 and unused sources never stall
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        chk("x0_no_lu", ctl(0), C_NONE);
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive_id(1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        chk("inv_no_lu", ctl(0), C_NONE);
        drive_id(1'b1, 5'd5, 5'd5, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        chk("unused_src_no_lu", ctl(0), C_NONE);
        drive_id(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        chk("rs2_lu", ctl(0), C_LU);

        // Multi-cycle op with MC_LAT=4: three wait cycles
        do_reset();
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        drive_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("mc_busy%0d", i), ex_busy[0], 1'b1);
            chk($sformatf("mc_ctl%0d", i), ctl(0), C_EXW);
            tick();
        end
        settle();
        chk("mc_done_busy", ex_busy[0], 1'b0);
        chk("mc_done_ctl", ctl(0), C_NONE);
        chk("mc_stall_cnt", stall_cycles[0], 3);

        // Reset asserted in the second ex_wait cycle
        do_reset();
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        drive_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        chk("rw_busy1", ex_busy[0], 1'b1);
        tick();
        reset = 1'b1;
        settle();
        chk("rw_rst_busy", ex_busy[0], 1'b0);
        chk("rw_rst_ctl", ctl(0), C_NONE);
        tick();
        reset = 1'b0;
        settle();
        chk("rw_after_busy", ex_busy[0], 1'b0);
        chk("rw_after_stall", stall_cycles[0], 0);
        chk("rw_after_flush", flush_count[0], 0);
        chk("rw_after_ctl", ctl(0), C_NONE);

        // MEM_LAT=3: taken branch in EX waits behind lw in MEM
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive_id(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("mw_c1_ctl", ctl(1), C_NONE);
        tick();
        br_taken = 1'b1;
        drive_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            settle();
            chk($sformatf("mw_busy%0d", i), mem_busy[1], 1'b1);
            chk($sformatf("mw_ctl%0d", i), ctl(1), C_MEMW);
            tick();
        end
        settle();
        chk("mw_redir_busy", mem_busy[1], 1'b0);
        chk("mw_redir_ctl", ctl(1), C_REDIR);
        tick();
        br_taken = 1'b0;
        settle();
        chk("mw_flush_cnt", flush_count[1], 1);
        chk("mw_stall_cnt", stall_cycles[1], 2);
        chk("mw_after_ctl", ctl(1), C_NONE);

        // FWD_EN=0: add x5 ; add x6,x5,x0 -> stall until writeback completes
        do_reset();
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("nf_ctl%0d", i), ctl(2), C_LU);
            chk($sformatf("nf_fwd%0d", i), {fwd_a_sel[2], fwd_b_sel[2]}, 4'b0000);
            tick();
        end
        settle();
        chk("nf_done_ctl", ctl(2), C_NONE);
        chk("nf_stall_cnt", stall_cycles[2], 3);

        // EX entry matching MEM: forwarded with FWD_EN=1, forced to register file with FWD_EN=0
        do_reset();
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive_id(1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        chk("nf_inv_no_lu", ctl(2), C_NONE);
        tick();
        nop_id();
        settle();
        chk("nf_fwd_forced", {fwd_a_sel[2], fwd_b_sel[2]}, 4'b0000);
        chk("fwd_on_match", {fwd_a_sel[0], fwd_b_sel[0]}, 4'b1010);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
